// File: rtl/uart_pkg.sv
// Shared encodings and defaults for the UART receive path (byte deserialiser and frame collector).
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 27;
  localparam int FRAME_BYTES      = 14;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_PARITY,
    B_STOP
  } bit_state_t;

  typedef enum logic {
    F_COLLECT,
    F_PUBLISH
  } frame_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// Deserialises one 8-data-bit + parity + 1-stop UART byte; strobes land the cycle after the stop sample.
// UART_RX_MAJORITY_EN: each sample is a 2-of-3 vote around mid-bit, decided one cycle later.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       parity_type,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       rx_busy,
  output logic       start_det
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] START_AT = CNT_W'(CLKS_PER_BIT / 2 + 1);
`else
  localparam logic [CNT_W-1:0] START_AT = CNT_W'(CLKS_PER_BIT / 2);
`endif

  bit_state_t       state, state_n;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n, byte_data_n;
  logic             par_bit, par_n;
  logic             byte_valid_n, parity_error_n, framing_error_n;
  logic             rx_meta, rx_sync, rx_prev, samp, fall;

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[0] is rx_sync one cycle ago, hist[1] two cycles ago.
  logic [1:0] hist;
  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) hist <= 2'b11;
    else        hist <= {hist[0], rx_sync};
  end
  assign samp = (rx_sync & hist[0]) | (rx_sync & hist[1]) | (hist[0] & hist[1]);
`else
  assign samp = rx_sync;
`endif

  assign fall      = rx_prev & ~rx_sync;
  assign start_det = (state == B_IDLE) && fall;
  assign rx_busy   = (state != B_IDLE);

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= B_IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      byte_data     <= '0;
      byte_valid    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      clk_cnt       <= clk_cnt_n;
      bit_cnt       <= bit_cnt_n;
      shreg         <= shreg_n;
      par_bit       <= par_n;
      byte_data     <= byte_data_n;
      byte_valid    <= byte_valid_n;
      parity_error  <= parity_error_n;
      framing_error <= framing_error_n;
    end
  end

  always_comb begin
    state_n         = state;
    clk_cnt_n       = clk_cnt;
    bit_cnt_n       = bit_cnt;
    shreg_n         = shreg;
    par_n           = par_bit;
    byte_data_n     = byte_data;
    byte_valid_n    = 1'b0;
    parity_error_n  = 1'b0;
    framing_error_n = 1'b0;
    case (state)
      B_IDLE: begin
        if (fall) begin
          state_n   = B_START;
          clk_cnt_n = '0;
        end
      end
      B_START: begin
        if (clk_cnt == START_AT) begin
          clk_cnt_n = '0;
          bit_cnt_n = '0;
          state_n   = samp ? B_IDLE : B_DATA;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      B_DATA: begin
        if (clk_cnt == LAST) begin
          clk_cnt_n = '0;
          shreg_n   = {samp, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
            bit_cnt_n = '0;
            state_n   = B_PARITY;
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      B_PARITY: begin
        if (clk_cnt == LAST) begin
          clk_cnt_n = '0;
          par_n     = samp;
          state_n   = B_STOP;
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      B_STOP: begin
        if (clk_cnt == LAST) begin
          clk_cnt_n = '0;
          state_n   = B_IDLE;
          // A bad stop bit masks any parity verdict: one strobe per byte.
          if (!samp)
            framing_error_n = 1'b1;
          else if ((^{shreg, par_bit}) != (parity_type == PARITY_ODD))
            parity_error_n = 1'b1;
          else begin
            byte_valid_n = 1'b1;
            byte_data_n  = shreg;
          end
        end else begin
          clk_cnt_n = clk_cnt + 1'b1;
        end
      end
      default: state_n = B_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Collects 14 consecutive good UART bytes and publishes them atomically with frame_valid.
// Build option UART_RX_MAJORITY_EN (see uart_rx_byte) selects 2-of-3 bit sampling.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int IDLE_TIMEOUT = 100000
) (
  input  logic                     clk_3125,
  input  logic                     rst_n,
  input  logic                     rx,
  input  logic                     parity_type,
  output logic [7:0]               byte_data,
  output logic                     byte_valid,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     parity_error,
  output logic                     framing_error,
  output logic                     timeout_error,
  output logic                     rx_busy
);

  localparam int TMO_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  logic                         start_det;
  logic [3:0]                   index;
  logic [8*(FRAME_BYTES-1)-1:0] slots;
  logic [TMO_W-1:0]             tmo_cnt, tmo_inc;
  logic                         tmo_run, tmo_hit;

  uart_rx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte (
    .clk_3125      (clk_3125),
    .rst_n         (rst_n),
    .rx            (rx),
    .parity_type   (parity_type),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .rx_busy       (rx_busy),
    .start_det     (start_det)
  );

  // A start bit landing on the expiry cycle suppresses the timeout.
  assign tmo_run = (index != 4'd0) && !rx_busy && !start_det && !byte_valid;
  assign tmo_inc = tmo_cnt + 1'b1;
  assign tmo_hit = tmo_run && (tmo_inc == TMO_W'(IDLE_TIMEOUT));

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      index         <= '0;
      slots         <= '0;
      frame_data    <= '0;
      frame_valid   <= 1'b0;
      timeout_error <= 1'b0;
      tmo_cnt       <= '0;
    end else begin
      frame_valid   <= 1'b0;
      timeout_error <= tmo_hit;
      if (!tmo_run || tmo_hit) tmo_cnt <= '0;
      else                     tmo_cnt <= tmo_inc;

      if (parity_error || framing_error || tmo_hit) begin
        index <= '0;
      end else if (byte_valid) begin
        if (index == LAST_IDX) begin
          index       <= '0;
          frame_data  <= {byte_data, slots};
          frame_valid <= 1'b1;
        end else begin
          slots[{index, 3'b000} +: 8] <= byte_data;
          index <= index + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: frames, parity/framing errors, timeout, glitch and mid-frame reset.
module tb_uart_rx_frame;

  localparam int CPB  = 27;
  localparam int TMO  = 2000;
  localparam int GAP  = 40;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT  = 288;
`else
  localparam int LAT  = 287;
`endif

  logic         clk_3125 = 1'b0;
  logic         rst_n = 1'b1;
  logic         rx = 1'b1;
  logic         parity_type = 1'b0;
  logic [7:0]   byte_data;
  logic         byte_valid;
  logic [111:0] frame_data;
  logic         frame_valid;
  logic         parity_error;
  logic         framing_error;
  logic         timeout_error;
  logic         rx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bv_cnt = 0, pe_cnt = 0, fe_cnt = 0, te_cnt = 0, fv_cnt = 0;
  int last_bv_cyc = 0, te_cyc = 0, start_cyc = 0;
  logic [7:0]   last_byte = '0;
  logic [111:0] last_frame = '0;

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB),
    .IDLE_TIMEOUT (TMO)
  ) dut (
    .clk_3125      (clk_3125),
    .rst_n         (rst_n),
    .rx            (rx),
    .parity_type   (parity_type),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .frame_data    (frame_data),
    .frame_valid   (frame_valid),
    .parity_error  (parity_error),
    .framing_error (framing_error),
    .timeout_error (timeout_error),
    .rx_busy       (rx_busy)
  );

  always #5 clk_3125 = ~clk_3125;
  always @(posedge clk_3125) cyc <= cyc + 1;

  always @(negedge clk_3125) begin
    if (byte_valid)    begin bv_cnt++; last_byte = byte_data; last_bv_cyc = cyc; end
    if (parity_error)  pe_cnt++;
    if (framing_error) fe_cnt++;
    if (timeout_error) begin te_cnt++; te_cyc = cyc; end
    if (frame_valid)   begin fv_cnt++; last_frame = frame_data; end
  end

  task automatic send_byte(input logic [7:0] d, input logic par, input logic stop);
    @(negedge clk_3125);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk_3125);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk_3125);
    end
    rx = par;
    repeat (CPB) @(negedge clk_3125);
    rx = stop;
    repeat (CPB) @(negedge clk_3125);
    rx = 1'b1;
    repeat (GAP) @(negedge clk_3125);
  endtask

  // Parity bit that makes the 9-bit popcount match parity_type.
  task automatic send_good(input logic [7:0] d);
    send_byte(d, (^d) ^ parity_type, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk_3125);
    checks++; if (byte_data !== 8'h00) begin failures++; $display("FAIL reset_byte_data got=%h exp=00", byte_data); end
    checks++; if (frame_data !== 112'h0) begin failures++; $display("FAIL reset_frame_data got=%h exp=0", frame_data); end
    checks++; if ({byte_valid, frame_valid, parity_error, framing_error, timeout_error, rx_busy} !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=000000",
        {byte_valid, frame_valid, parity_error, framing_error, timeout_error, rx_busy});
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk_3125);
  endtask

  task automatic test_frame;
    int bv0, fv0, err0;
    logic [111:0] exp;
    parity_type = 1'b0;
    bv0 = bv_cnt; fv0 = fv_cnt; err0 = pe_cnt + fe_cnt + te_cnt;
    send_good(8'h00);
    checks++; if (last_bv_cyc - start_cyc !== LAT) begin failures++; $display("FAIL byte_latency got=%0d exp=%0d", last_bv_cyc - start_cyc, LAT); end
    for (int i = 1; i < 14; i++) send_good(8'(i));
    for (int i = 0; i < 14; i++) exp[8*i +: 8] = 8'(i);
    checks++; if (bv_cnt - bv0 !== 14) begin failures++; $display("FAIL frame_byte_count got=%0d exp=14", bv_cnt - bv0); end
    checks++; if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL frame_valid_count got=%0d exp=1", fv_cnt - fv0); end
    checks++; if (frame_data[7:0] !== 8'h00) begin failures++; $display("FAIL frame_byte0 got=%h exp=00", frame_data[7:0]); end
    checks++; if (frame_data[111:104] !== 8'h0D) begin failures++; $display("FAIL frame_byte13 got=%h exp=0d", frame_data[111:104]); end
    checks++; if (last_frame !== exp) begin failures++; $display("FAIL frame_content got=%h exp=%h", last_frame, exp); end
    checks++; if (pe_cnt + fe_cnt + te_cnt - err0 !== 0) begin failures++; $display("FAIL frame_no_errors got=%0d exp=0", pe_cnt + fe_cnt + te_cnt - err0); end
  endtask

  task automatic test_parity;
    int bv0, pe0, fv0;
    logic [111:0] exp;
    parity_type = 1'b1;
    send_good(8'h11);
    send_good(8'h22);
    bv0 = bv_cnt; pe0 = pe_cnt; fv0 = fv_cnt;
    // 0xA5 has four ones; parity bit 0 leaves the total even, wrong for odd parity.
    send_byte(8'hA5, 1'b0, 1'b1);
    checks++; if (pe_cnt - pe0 !== 1) begin failures++; $display("FAIL parity_err_count got=%0d exp=1", pe_cnt - pe0); end
    checks++; if (bv_cnt - bv0 !== 0) begin failures++; $display("FAIL parity_no_byte got=%0d exp=0", bv_cnt - bv0); end
    send_byte(8'hA5, 1'b1, 1'b1);
    checks++; if (bv_cnt - bv0 !== 1) begin failures++; $display("FAIL parity_good_count got=%0d exp=1", bv_cnt - bv0); end
    checks++; if (byte_data !== 8'hA5) begin failures++; $display("FAIL parity_byte_data got=%h exp=a5", byte_data); end
    exp[7:0] = 8'hA5;
    for (int i = 1; i < 14; i++) begin
      exp[8*i +: 8] = 8'(8'h30 + i);
      send_good(8'(8'h30 + i));
    end
    checks++; if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL parity_frame_count got=%0d exp=1", fv_cnt - fv0); end
    checks++; if (last_frame !== exp) begin failures++; $display("FAIL parity_frame_content got=%h exp=%h", last_frame, exp); end
    parity_type = 1'b0;
  endtask

  task automatic test_timeout;
    int te0, fv0;
    logic [111:0] exp;
    te0 = te_cnt;
    for (int i = 0; i < 5; i++) send_good(8'(8'hE0 + i));
    repeat (2500) @(negedge clk_3125);
    checks++; if (te_cnt - te0 !== 1) begin failures++; $display("FAIL timeout_count got=%0d exp=1", te_cnt - te0); end
    checks++; if (te_cyc - last_bv_cyc !== TMO + 1) begin failures++; $display("FAIL timeout_cycle got=%0d exp=%0d", te_cyc - last_bv_cyc, TMO + 1); end
    fv0 = fv_cnt;
    for (int i = 0; i < 14; i++) begin
      exp[8*i +: 8] = 8'(8'h40 + i);
      send_good(8'(8'h40 + i));
    end
    checks++; if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL timeout_frame_count got=%0d exp=1", fv_cnt - fv0); end
    checks++; if (last_frame !== exp) begin failures++; $display("FAIL timeout_frame_content got=%h exp=%h", last_frame, exp); end
  endtask

  task automatic test_framing;
    int bv0, pe0, fe0;
    bv0 = bv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    // 0x3C has four ones: even parity wants 0, so 1 is also wrong.
    send_byte(8'h3C, 1'b1, 1'b0);
    checks++; if (fe_cnt - fe0 !== 1) begin failures++; $display("FAIL framing_err_count got=%0d exp=1", fe_cnt - fe0); end
    checks++; if (pe_cnt - pe0 !== 0) begin failures++; $display("FAIL framing_no_parity got=%0d exp=0", pe_cnt - pe0); end
    checks++; if (bv_cnt - bv0 !== 0) begin failures++; $display("FAIL framing_no_byte got=%0d exp=0", bv_cnt - bv0); end
  endtask

  task automatic test_glitch;
    int bv0, pe0, fe0, fv0;
    logic [111:0] exp;
    exp[7:0] = 8'h71; exp[15:8] = 8'h72;
    send_good(8'h71);
    send_good(8'h72);
    bv0 = bv_cnt; pe0 = pe_cnt; fe0 = fe_cnt; fv0 = fv_cnt;
    @(negedge clk_3125);
    rx = 1'b0;
    repeat (8) @(negedge clk_3125);
    checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_high got=%b exp=1", rx_busy); end
    repeat (2) @(negedge clk_3125);
    rx = 1'b1;
    repeat (60) @(negedge clk_3125);
    checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_low got=%b exp=0", rx_busy); end
    checks++; if ((bv_cnt - bv0) + (pe_cnt - pe0) + (fe_cnt - fe0) !== 0) begin
      failures++; $display("FAIL glitch_no_strobe got=%0d exp=0", (bv_cnt - bv0) + (pe_cnt - pe0) + (fe_cnt - fe0));
    end
    for (int i = 2; i < 14; i++) begin
      exp[8*i +: 8] = 8'(8'h70 + i + 1);
      send_good(8'(8'h70 + i + 1));
    end
    checks++; if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL glitch_frame_count got=%0d exp=1", fv_cnt - fv0); end
    checks++; if (last_frame !== exp) begin failures++; $display("FAIL glitch_frame_content got=%h exp=%h", last_frame, exp); end
  endtask

  task automatic test_reset_mid;
    int fv0;
    logic [111:0] exp;
    for (int i = 0; i < 8; i++) send_good(8'(8'h90 + i));
    checks++; if (frame_data === 112'h0) begin failures++; $display("FAIL pre_reset_frame got=%h exp=nonzero", frame_data); end
    @(negedge clk_3125);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_3125);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (CPB) @(negedge clk_3125);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (frame_data !== 112'h0) begin failures++; $display("FAIL midrst_frame_data got=%h exp=0", frame_data); end
    checks++; if (byte_data !== 8'h00) begin failures++; $display("FAIL midrst_byte_data got=%h exp=00", byte_data); end
    checks++; if ({byte_valid, frame_valid, parity_error, framing_error, timeout_error, rx_busy} !== 6'b0) begin
      failures++; $display("FAIL midrst_strobes got=%b exp=000000",
        {byte_valid, frame_valid, parity_error, framing_error, timeout_error, rx_busy});
    end
    rx = 1'b1;
    repeat (5) @(negedge clk_3125);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_3125);
    fv0 = fv_cnt;
    for (int i = 0; i < 14; i++) begin
      exp[8*i +: 8] = 8'(8'hC0 + i);
      send_good(8'(8'hC0 + i));
    end
    checks++; if (fv_cnt - fv0 !== 1) begin failures++; $display("FAIL midrst_frame_count got=%0d exp=1", fv_cnt - fv0); end
    checks++; if (frame_data !== exp) begin failures++; $display("FAIL midrst_frame_content got=%h exp=%h", frame_data, exp); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_parity();
    test_timeout();
    test_framing();
    test_glitch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
